// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
//   state_t         - bridge FSM states
//   rsp_t           - registered response record (rdata, err, timeout)
//   TIMER_CLEAR_CMD - value written to the millisecond timer to clear it
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

  localparam logic [31:0] TIMER_CLEAR_CMD = 32'd1514;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter for the ACCESS phase.
//   pclk, preset : clock, asynchronous active-high reset
//   clr          : reset the count to zero (entry to SETUP)
//   en           : count one more low-pready cycle
//   expired      : count has reached TIMEOUT-1; always 0 when TIMEOUT == 0
module apb_wait_timer #(
  parameter int TIMEOUT = 256,
  parameter int TOW     = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TOW-1:0] count;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + TOW'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      localparam logic [TOW-1:0] LIMIT = TOW'(TIMEOUT - 1);
      // The count is checked before this cycle's increment, so expiry on
      // count == TIMEOUT-1 aborts after exactly TIMEOUT low-pready cycles.
      assign expired = (count >= LIMIT);
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready command in, APB transfer,
// valid/ready response out.
//   pclk, preset                      : clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata  : command stream
//   rsp_valid/ready/rdata/err/timeout : response stream
//   psel/penable/pwrite/paddr/pwdata  : APB request
//   prdata/pready/pslverr             : APB completion
//
// state  | meaning
// IDLE   | cmd_ready=1, waiting for a command
// SETUP  | psel=1, penable=0, one cycle
// ACCESS | psel=1, penable=1, waiting for pready or timeout
// RESP   | rsp_valid=1, holding response until rsp_ready
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int TIMEOUT   = 256,
  parameter int TOW       = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDRWIDTH-1:0] paddr,
  output logic [31:0]          pwdata,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  state_t state, state_nxt;
  rsp_t   rsp_q, rsp_nxt;
  logic   cmd_take;
  logic   rsp_load;
  logic   tmr_clr;
  logic   tmr_en;
  logic   tmr_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TOW     (TOW)
  ) u_wait_timer (
    .pclk    (pclk),
    .preset  (preset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_take  = 1'b0;
    rsp_load  = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    rsp_nxt   = '0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_take  = 1'b1;
          tmr_clr   = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_load      = 1'b1;
          rsp_nxt.rdata = pwrite ? 32'd0 : prdata;
          rsp_nxt.err   = pslverr;
          state_nxt     = ST_RESP;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            rsp_load        = 1'b1;
            rsp_nxt.err     = 1'b1;
            rsp_nxt.timeout = 1'b1;
            state_nxt       = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address/direction/data stay put from capture until the next command,
  // which keeps them stable across SETUP and ACCESS. Reads leave pwdata alone.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      rsp_q  <= '0;
    end else begin
      if (cmd_take) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        if (cmd_write) begin
          pwdata <= cmd_wdata;
        end
      end
      if (rsp_load) begin
        rsp_q <= rsp_nxt;
      end
    end
  end

  // Decoded from registered state so all handshake/strobe outputs drop
  // together the moment preset rises.
  assign cmd_ready   = (state == ST_IDLE);
  assign psel        = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable     = (state == ST_ACCESS);
  assign rsp_valid   = (state == ST_RESP);
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW  = 12;
  localparam int TMO = 8;

  logic          pclk, preset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;
  logic          pready, pslverr;

  int tests  = 0;
  int failed = 0;
  logic [31:0] last_wdata = 32'd0;

  apb_master_bridge #(.ADDRWIDTH(AW), .TIMEOUT(TMO), .TOW(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            waits;
    logic          slv;
    logic [31:0]   prd;
    int            hold;
    logic [31:0]   e_rdata;
    logic          e_err;
    logic          e_to;
    int            e_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a transfer ends either on the first high pready or after TMO
  // low cycles, whichever comes first; SETUP plus handshake add two cycles.
  function automatic void model(input logic wr, input int waits, input logic slv,
                                input logic [31:0] rd, output logic [31:0] e_rdata,
                                output logic e_err, output logic e_to, output int e_lat);
    if (TMO != 0 && waits >= TMO) begin
      e_rdata = 32'd0; e_err = 1'b1; e_to = 1'b1; e_lat = 2 + TMO;
    end else begin
      e_rdata = wr ? 32'd0 : rd; e_err = slv; e_to = 1'b0; e_lat = 3 + waits;
    end
  endfunction

  // Called and returns at a negedge with the bridge idle.
  task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                      input logic [31:0] wd, input int waits, input logic slv,
                      input logic [31:0] rd, input int hold, input logic [31:0] e_rdata,
                      input logic e_err, input logic e_to, input int e_lat);
    int c, acc;
    logic done;
    logic [31:0] r_rdata;
    logic r_err, r_to;
    chk({tag, ".cmd_ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
    if (wr) last_wdata = wd;
    c = 0; acc = 0; done = 1'b0;
    r_rdata = '0; r_err = 1'b0; r_to = 1'b0;
    while (!done && c < 300) begin
      @(negedge pclk);
      c++;
      // A competing command while busy must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = $urandom;
      chk({tag, ".pen_wo_psel"}, penable & ~psel, 1'b0);
      if (c == 1) begin
        chk({tag, ".setup_psel"}, psel, 1'b1);
        chk({tag, ".setup_pen"}, penable, 1'b0);
      end
      if (psel) begin
        chk({tag, ".paddr"}, paddr, addr);
        chk({tag, ".pwrite"}, pwrite, wr);
        chk({tag, ".pwdata"}, pwdata, last_wdata);
      end
      if (rsp_valid) begin
        done = 1'b1;
        chk({tag, ".latency"}, c, e_lat);
        chk({tag, ".rsp_psel"}, psel, 1'b0);
        chk({tag, ".rsp_rdata"}, rsp_rdata, e_rdata);
        chk({tag, ".rsp_err"}, rsp_err, e_err);
        chk({tag, ".rsp_timeout"}, rsp_timeout, e_to);
        r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
        pready = 1'b0;
      end else if (penable) begin
        pready  = (acc >= waits);
        pslverr = pready ? slv : 1'($urandom);
        prdata  = pready ? rd : $urandom;
        acc++;
      end else begin
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
    end
    if (!done) begin
      tests++; failed++;
      $display("FAIL %s.no_response: got none after %0d cycles, want rsp_valid", tag, c);
      cmd_valid = 1'b0;
      return;
    end
    for (int h = 1; h <= hold; h++) begin
      @(negedge pclk);
      chk({tag, ".hold_valid"}, rsp_valid, 1'b1);
      chk({tag, ".hold_rdata"}, rsp_rdata, r_rdata);
      chk({tag, ".hold_err"}, {rsp_err, rsp_timeout}, {r_err, r_to});
      chk({tag, ".hold_cmd_ready"}, cmd_ready, 1'b0);
      chk({tag, ".hold_psel"}, psel, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk({tag, ".post_valid"}, rsp_valid, 1'b0);
    chk({tag, ".post_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] e_rdata;
    logic e_err, e_to;
    int e_lat;

    vecs[0] = '{1'b1, 12'h004, TIMER_CLEAR_CMD, 0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 12'h010, 32'h0, 3, 1'b0, 32'h0000_0042, 0, 32'h0000_0042, 1'b0, 1'b0, 6};
    vecs[2] = '{1'b0, 12'h020, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 3};
    vecs[3] = '{1'b0, 12'h030, 32'h0, 100, 1'b0, 32'h1111_1111, 0, 32'h0, 1'b1, 1'b1, 10};
    vecs[4] = '{1'b1, 12'h008, 32'h0000_1234, 1, 1'b0, 32'hFFFF_FFFF, 5, 32'h0, 1'b0, 1'b0, 4};
    vecs[5] = '{1'b1, 12'h00C, 32'hA5A5_5A5A, 2, 1'b1, 32'h5555_0000, 0, 32'h0, 1'b1, 1'b0, 5};
    vecs[6] = '{1'b0, 12'h040, 32'h0, 7, 1'b0, 32'h0000_0077, 0, 32'h0000_0077, 1'b0, 1'b0, 10};
    vecs[7] = '{1'b0, 12'h044, 32'h0, 8, 1'b0, 32'h0000_0088, 0, 32'h0, 1'b1, 1'b1, 10};

    preset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    chk("reset.cmd_ready", cmd_ready, 1'b1);
    chk("reset.strobes", {psel, penable, pwrite, rsp_valid}, 4'b0000);
    chk("reset.paddr", paddr, 12'h000);
    chk("reset.pwdata", pwdata, 32'h0);
    chk("reset.rsp", {rsp_err, rsp_timeout}, 2'b00);
    chk("reset.rsp_rdata", rsp_rdata, 32'h0);
    preset = 1'b0;
    @(negedge pclk);

    for (int i = 0; i < 8; i++) begin
      xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
           vecs[i].waits, vecs[i].slv, vecs[i].prd, vecs[i].hold,
           vecs[i].e_rdata, vecs[i].e_err, vecs[i].e_to, vecs[i].e_lat);
    end

    // Reset during the second wait state of a read.
    chk("rst_mid.cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h0AB; pready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("rst_mid.in_access", {psel, penable}, 2'b11);
    preset = 1'b1;
    #1;
    chk("rst_mid.strobes", {psel, penable, rsp_valid}, 3'b000);
    chk("rst_mid.cmd_ready", cmd_ready, 1'b1);
    chk("rst_mid.paddr", paddr, 12'h000);
    @(negedge pclk);
    preset = 1'b0;
    last_wdata = 32'd0;
    pready = 1'b1; prdata = 32'h0000_00AB;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("rst_mid.no_rsp", {rsp_valid, psel}, 2'b00);
    end
    chk("rst_mid.pwdata", pwdata, 32'h0);
    xfer("rst_after", 1'b0, 12'h0AC, 32'h0, 1, 1'b0, 32'h0000_0099, 0,
         32'h0000_0099, 1'b0, 1'b0, 4);

    for (int i = 0; i < 40; i++) begin
      logic wr, slv;
      logic [AW-1:0] a;
      logic [31:0] wd, rd;
      int w, h;
      wr = 1'($urandom); slv = ($urandom_range(0, 3) == 0);
      a = AW'($urandom); wd = $urandom; rd = $urandom;
      w = $urandom_range(0, 11); h = $urandom_range(0, 3);
      model(wr, w, slv, rd, e_rdata, e_err, e_to, e_lat);
      xfer($sformatf("rnd%0d", i), wr, a, wd, w, slv, rd, h, e_rdata, e_err, e_to, e_lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
